// File: rtl/bus_arbiter.sv
`default_nettype none
// ==========================================================================
// bus_arbiter : round-robin owner select driving one-hot tristate enables
// Rev 1.0
// ==========================================================================
module bus_arbiter #(
  parameter int NREQ     = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [NREQ-1:0] req_i,
  input  logic [NREQ-1:0] done_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [NREQ-1:0] oe_o,
  output logic            busy_o,
  output logic            timeout_o
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam logic [PW-1:0] c_last     = PW'(NREQ - 1);
  localparam logic [HW-1:0] c_max_hold = HW'(MAX_HOLD);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_DRIVE = 2'd2,
    S_TURN  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [PW-1:0]   owner_q, owner_d;
  logic [HW-1:0]   hold_q, hold_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREQ-1:0] oe_q, oe_d;
  logic            busy_q, busy_d;
  logic            timeout_q, timeout_d;

  logic [PW-1:0]   next_ptr;
  logic [PW-1:0]   arb_base;
  logic [PW-1:0]   arb_win;
  logic            arb_any;

  function automatic logic [NREQ-1:0] onehot(input logic [PW-1:0] idx);
    logic [NREQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  assign next_ptr = (owner_q == c_last) ? '0 : owner_q + 1'b1;
  // TURN arbitrates with the pointer it is about to commit, not the stale one.
  assign arb_base = (state_q == S_TURN) ? next_ptr : ptr_q;
  assign arb_any  = |req_i;

  always_comb begin : p_arb
    int j;
    j       = 0;
    arb_win = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      j = (int'(arb_base) + i) % NREQ;
      if (req_i[j[PW-1:0]]) arb_win = j[PW-1:0];
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    owner_d   = owner_q;
    hold_d    = hold_q;
    gnt_d     = gnt_q;
    oe_d      = oe_q;
    timeout_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        gnt_d  = '0;
        oe_d   = '0;
        hold_d = '0;
        if (arb_any) begin
          owner_d = arb_win;
          gnt_d   = onehot(arb_win);
          state_d = S_GRANT;
        end
      end
      S_GRANT: begin
        if (req_i[owner_q]) begin
          oe_d    = onehot(owner_q);
          hold_d  = HW'(1);
          state_d = S_DRIVE;
        end else begin
          gnt_d   = '0;
          oe_d    = '0;
          state_d = S_TURN;
        end
      end
      S_DRIVE: begin
        if (done_i[owner_q] || !req_i[owner_q]) begin
          gnt_d   = '0;
          oe_d    = '0;
          hold_d  = '0;
          state_d = S_TURN;
        end else if (hold_q == c_max_hold) begin
          gnt_d     = '0;
          oe_d      = '0;
          hold_d    = '0;
          timeout_d = 1'b1;
          state_d   = S_TURN;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      S_TURN: begin
        ptr_d  = next_ptr;
        oe_d   = '0;
        hold_d = '0;
        if (arb_any) begin
          owner_d = arb_win;
          gnt_d   = onehot(arb_win);
          state_d = S_GRANT;
        end else begin
          gnt_d   = '0;
          state_d = S_IDLE;
        end
      end
      default: begin
        gnt_d   = '0;
        oe_d    = '0;
        hold_d  = '0;
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      ptr_q     <= '0;
      owner_q   <= '0;
      hold_q    <= '0;
      gnt_q     <= '0;
      oe_q      <= '0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      owner_q   <= owner_d;
      hold_q    <= hold_d;
      gnt_q     <= gnt_d;
      oe_q      <= oe_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
    end
  end

  assign gnt_o     = gnt_q;
  assign oe_o      = oe_q;
  assign busy_o    = busy_q;
  assign timeout_o = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_bus_arbiter.sv
`default_nettype none
// ==========================================================================
// tb_bus_arbiter : scoreboard bench for bus_arbiter (NREQ=4, MAX_HOLD=8)
// Rev 1.0
// ==========================================================================
module tb_bus_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [3:0] done;
  logic [3:0] gnt;
  logic [3:0] oe;
  logic       busy;
  logic       tout;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [3:0] g;
    logic [3:0] o;
    logic       b;
    logic       t;
  } obs_t;

  obs_t exp_q[$];
  obs_t obs_q[$];

  always #5 clk = ~clk;

  bus_arbiter #(.NREQ(4), .MAX_HOLD(8)) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .req_i     (req),
    .done_i    (done),
    .gnt_o     (gnt),
    .oe_o      (oe),
    .busy_o    (busy),
    .timeout_o (tout)
  );

  task automatic tick();
    @(posedge clk);
    #1;
    obs_q.push_back('{gnt, oe, busy, tout});
  endtask

  // Drive one cycle of inputs and record what must appear after the next edge.
  task automatic cyc(input logic [3:0] r, input logic [3:0] d, input logic [3:0] g,
                     input logic [3:0] o, input logic b, input logic t);
    req  = r;
    done = d;
    exp_q.push_back('{g, o, b, t});
    tick();
  endtask

  task automatic do_reset();
    req  = '0;
    done = '0;
    rst  = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_reset();
    obs_t e, o;
    int   idx;
    req  = '0;
    done = '0;
    rst  = 1'b0;
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({gnt, oe, busy, tout} !== 10'b0) begin
      errors++;
      $display("FAIL reset_initial: got gnt=%b oe=%b busy=%b to=%b, expected all zero", gnt, oe, busy, tout);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    cyc(4'b0010, 4'b0000, 4'b0010, 4'b0000, 1'b1, 1'b0);
    cyc(4'b0010, 4'b0000, 4'b0010, 4'b0010, 1'b1, 1'b0);
    idx = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL reset_setup[%0d]: got gnt=%b oe=%b busy=%b to=%b, expected gnt=%b oe=%b busy=%b to=%b",
                 idx, o.g, o.o, o.b, o.t, e.g, e.o, e.b, e.t);
      end
      idx++;
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({gnt, oe, busy, tout} !== 10'b0) begin
      errors++;
      $display("FAIL reset_mid_drive: got gnt=%b oe=%b busy=%b to=%b, expected all zero", gnt, oe, busy, tout);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    cyc(4'b1111, 4'b0000, 4'b0001, 4'b0000, 1'b1, 1'b0);
    idx = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL reset_ptr0[%0d]: got gnt=%b oe=%b busy=%b to=%b, expected gnt=%b oe=%b busy=%b to=%b",
                 idx, o.g, o.o, o.b, o.t, e.g, e.o, e.b, e.t);
      end
      idx++;
    end
    do_reset();
  endtask

  task automatic test_single();
    obs_t e, o;
    int   idx;
    cyc(4'b0100, 4'b0000, 4'b0100, 4'b0000, 1'b1, 1'b0);
    cyc(4'b0100, 4'b0000, 4'b0100, 4'b0100, 1'b1, 1'b0);
    cyc(4'b0100, 4'b0000, 4'b0100, 4'b0100, 1'b1, 1'b0);
    cyc(4'b0100, 4'b0000, 4'b0100, 4'b0100, 1'b1, 1'b0);
    cyc(4'b0100, 4'b0100, 4'b0000, 4'b0000, 1'b1, 1'b0);
    cyc(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0);
    idx = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL single[%0d]: got gnt=%b oe=%b busy=%b to=%b, expected gnt=%b oe=%b busy=%b to=%b",
                 idx, o.g, o.o, o.b, o.t, e.g, e.o, e.b, e.t);
      end
      idx++;
    end
    do_reset();
  endtask

  task automatic test_round_robin();
    obs_t       e, o;
    int         idx;
    logic [3:0] g;
    for (int k = 0; k < 5; k++) begin
      g = 4'b0001 << (k % 4);
      cyc(4'b1111, 4'b1111, g,       4'b0000, 1'b1, 1'b0);
      cyc(4'b1111, 4'b1111, g,       g,       1'b1, 1'b0);
      cyc(4'b1111, 4'b1111, 4'b0000, 4'b0000, 1'b1, 1'b0);
    end
    cyc(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0);
    idx = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL round_robin[%0d]: got gnt=%b oe=%b busy=%b to=%b, expected gnt=%b oe=%b busy=%b to=%b",
                 idx, o.g, o.o, o.b, o.t, e.g, e.o, e.b, e.t);
      end
      idx++;
    end
    do_reset();
  endtask

  task automatic test_timeout();
    obs_t       e, o;
    int         idx;
    logic [3:0] r;
    cyc(4'b0010, 4'b0000, 4'b0010, 4'b0000, 1'b1, 1'b0);
    // Other requesters arrive mid-ownership; they must not disturb the owner.
    for (int k = 2; k <= 9; k++) begin
      r = (k >= 5) ? 4'b1011 : 4'b0010;
      cyc(r, 4'b0000, 4'b0010, 4'b0010, 1'b1, 1'b0);
    end
    cyc(4'b1011, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b1);
    cyc(4'b1011, 4'b0000, 4'b1000, 4'b0000, 1'b1, 1'b0);
    cyc(4'b1011, 4'b1111, 4'b1000, 4'b1000, 1'b1, 1'b0);
    cyc(4'b1011, 4'b1111, 4'b0000, 4'b0000, 1'b1, 1'b0);
    cyc(4'b1011, 4'b1111, 4'b0001, 4'b0000, 1'b1, 1'b0);
    cyc(4'b1011, 4'b1111, 4'b0001, 4'b0001, 1'b1, 1'b0);
    cyc(4'b1011, 4'b1111, 4'b0000, 4'b0000, 1'b1, 1'b0);
    cyc(4'b1011, 4'b1111, 4'b0010, 4'b0000, 1'b1, 1'b0);
    cyc(4'b1011, 4'b1111, 4'b0010, 4'b0010, 1'b1, 1'b0);
    cyc(4'b1011, 4'b1111, 4'b0000, 4'b0000, 1'b1, 1'b0);
    cyc(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0);
    idx = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL timeout[%0d]: got gnt=%b oe=%b busy=%b to=%b, expected gnt=%b oe=%b busy=%b to=%b",
                 idx, o.g, o.o, o.b, o.t, e.g, e.o, e.b, e.t);
      end
      idx++;
    end
    do_reset();
  endtask

  task automatic test_abort();
    obs_t e, o;
    int   idx;
    cyc(4'b1000, 4'b1111, 4'b1000, 4'b0000, 1'b1, 1'b0);
    cyc(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0);
    cyc(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0);
    // Pointer wrapped from 3 back to 0, so requester 0 must win.
    cyc(4'b1111, 4'b0000, 4'b0001, 4'b0000, 1'b1, 1'b0);
    idx = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL abort[%0d]: got gnt=%b oe=%b busy=%b to=%b, expected gnt=%b oe=%b busy=%b to=%b",
                 idx, o.g, o.o, o.b, o.t, e.g, e.o, e.b, e.t);
      end
      idx++;
    end
    do_reset();
  endtask

  task automatic test_contention();
    logic [3:0] prev_oe;
    logic       prev_to;
    prev_oe = '0;
    prev_to = 1'b0;
    for (int n = 0; n < 4000; n++) begin
      req  = 4'($urandom);
      done = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
      @(posedge clk);
      #1;
      checks++;
      if (!$onehot0(gnt) || !$onehot0(oe) || ((oe & ~gnt) != 4'b0000)) begin
        errors++;
        $display("FAIL contention_onehot[%0d]: got gnt=%b oe=%b, required one-hot-or-zero with oe within gnt",
                 n, gnt, oe);
      end
      checks++;
      if ((prev_oe != 4'b0000) && (oe != 4'b0000) && (oe != prev_oe)) begin
        errors++;
        $display("FAIL contention_turn[%0d]: got oe %b -> %b, required a zero-oe cycle between owners",
                 n, prev_oe, oe);
      end
      checks++;
      if (tout && (prev_to || (oe != 4'b0000) || (gnt != 4'b0000))) begin
        errors++;
        $display("FAIL contention_timeout[%0d]: got to=%b prev_to=%b gnt=%b oe=%b, required single pulse in dead cycle",
                 n, tout, prev_to, gnt, oe);
      end
      prev_oe = oe;
      prev_to = tout;
    end
    do_reset();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_timeout();
    test_abort();
    test_contention();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
